// File: rtl/ddr4_resp_pkg.sv
// Shared types and command decode for the DDR4 command responder.
package ddr4_resp_pkg;

  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, REF, ILL} cmd_e;
  typedef enum logic [1:0] {IDLE, OPENING, ACTIVE} bank_st_e;

  localparam int NUM_BANKS = 16;

  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    cmd_e c;
    if (cs_n) begin
      c = NOP;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b111:  c = NOP;
        3'b011:  c = ACT;
        3'b101:  c = RD;
        3'b100:  c = WR;
        3'b010:  c = PRE;
        3'b001:  c = REF;
        default: c = ILL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr4_bank_fsm.sv
// One DDR4 bank: IDLE/OPENING/ACTIVE state, tRCD countdown and latched open row.
module ddr4_bank_fsm
  import ddr4_resp_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int TRCD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             pre,
  input  logic [ROW_W-1:0] row,
  output logic             idle,
  output logic             ready,
  output logic [ROW_W-1:0] open_row
);

  localparam int CNT_W = (TRCD > 1) ? $clog2(TRCD) : 1;

  bank_st_e         state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ROW_W-1:0] row_reg, row_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    case (state_reg)
      IDLE: begin
        if (act) begin
          state_next = OPENING;
          cnt_next   = CNT_W'(TRCD - 1);
          row_next   = row;
        end
      end
      OPENING: begin
        if (pre)               state_next = IDLE;
        else if (cnt_reg == '0) state_next = ACTIVE;
        else                   cnt_next   = cnt_reg - 1'b1;
      end
      ACTIVE: begin
        if (pre) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final OPENING cycle (count at zero) already accepts column commands.
  assign idle     = (state_reg == IDLE);
  assign ready    = (state_reg == ACTIVE) || (state_reg == OPENING && cnt_reg == '0);
  assign open_row = row_reg;

endmodule

// File: rtl/ddr4_cmd_responder.sv
// DDR4 device-side responder: command decode, per-bank state, storage array and CL/CWL pipelines.
// Optional DDR4_RESP_STATS_EN adds saturating command/error counters.
module ddr4_cmd_responder
  import ddr4_resp_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  parameter int CL    = 4,
  parameter int CWL   = 3,
  parameter int TRCD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ddr4_cs_n,
  input  logic        ddr4_ras_n,
  input  logic        ddr4_cas_n,
  input  logic        ddr4_we_n,
  input  logic [15:0] ddr4_addr,
  input  logic [2:0]  ddr4_ba,
  input  logic [1:0]  ddr4_bg,
  input  logic [15:0] ddr4_dq_i,
  output logic [15:0] ddr4_dq_o,
  output logic        ddr4_dq_oe,
  output logic [15:0] bank_open,
  output logic        cmd_err
`ifdef DDR4_RESP_STATS_EN
  ,
  output logic [15:0] stat_act,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_wr,
  output logic [15:0] stat_err
`endif
);

  localparam int ADDR_W = 4 + ROW_W + COL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  cmd_e                 cmd;
  logic [3:0]           bank_idx;
  logic                 ba_bad;
  logic [NUM_BANKS-1:0] idle_vec, ready_vec, act_vec, pre_vec;
  logic [ROW_W-1:0]     row_arr [NUM_BANKS];
  logic                 act_ok, rd_ok, wr_ok, pre_ok, conflict, err_now;
  logic [ADDR_W-1:0]    acc_addr;
  logic                 unused_addr;

  assign cmd         = decode_cmd(ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n);
  assign bank_idx    = {ddr4_bg, ddr4_ba[1:0]};
  assign ba_bad      = ddr4_ba[2];
  assign unused_addr = ^ddr4_addr;

  assign act_ok = (cmd == ACT) && !ba_bad && idle_vec[bank_idx];
  assign rd_ok  = (cmd == RD)  && !ba_bad && ready_vec[bank_idx];
  assign wr_ok  = (cmd == WR)  && !ba_bad && ready_vec[bank_idx];
  assign pre_ok = (cmd == PRE) && !ba_bad;
  assign acc_addr = {bank_idx, row_arr[bank_idx], ddr4_addr[COL_W-1:0]};

  genvar gi;
  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign act_vec[gi] = act_ok && (bank_idx == 4'(gi));
    assign pre_vec[gi] = pre_ok && (ddr4_addr[10] || bank_idx == 4'(gi));

    ddr4_bank_fsm #(.ROW_W(ROW_W), .TRCD(TRCD)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .act      (act_vec[gi]),
      .pre      (pre_vec[gi]),
      .row      (ddr4_addr[ROW_W-1:0]),
      .idle     (idle_vec[gi]),
      .ready    (ready_vec[gi]),
      .open_row (row_arr[gi])
    );
  end

  // Read pipeline holds CL-1 stages; the array read itself is the last stage.
  logic [CL-2:0]     rd_v_reg, rd_v_next;
  logic [ADDR_W-1:0] rd_a_reg [CL-1];
  logic [ADDR_W-1:0] rd_a_next [CL-1];
  logic [CWL-1:0]    wr_v_reg, wr_v_next;
  logic [ADDR_W-1:0] wr_a_reg [CWL];
  logic [ADDR_W-1:0] wr_a_next [CWL];

  assign rd_v_next[0] = rd_ok;
  assign rd_a_next[0] = acc_addr;
  for (gi = 1; gi < CL - 1; gi++) begin : g_rd_pipe
    assign rd_v_next[gi] = rd_v_reg[gi-1];
    assign rd_a_next[gi] = rd_a_reg[gi-1];
  end

  assign wr_v_next[0] = wr_ok;
  assign wr_a_next[0] = acc_addr;
  for (gi = 1; gi < CWL; gi++) begin : g_wr_pipe
    assign wr_v_next[gi] = wr_v_reg[gi-1];
    assign wr_a_next[gi] = wr_a_reg[gi-1];
  end

  logic [15:0] mem [DEPTH];
  logic [15:0] rd_data_reg;
  logic        dq_oe_reg, cmd_err_reg;

  always_ff @(posedge clk) begin
    if (!rst && wr_v_reg[CWL-1]) mem[wr_a_reg[CWL-1]] <= ddr4_dq_i;
    rd_data_reg <= mem[rd_a_reg[CL-2]];
    rd_a_reg    <= rd_a_next;
    wr_a_reg    <= wr_a_next;
  end

  assign conflict = wr_v_reg[CWL-1] && dq_oe_reg;

  always_comb begin
    err_now = 1'b0;
    case (cmd)
      ILL:     err_now = 1'b1;
      ACT:     err_now = ba_bad || !idle_vec[bank_idx];
      RD, WR:  err_now = ba_bad || !ready_vec[bank_idx];
      PRE:     err_now = ba_bad;
      REF:     err_now = !(&idle_vec);
      default: err_now = 1'b0;
    endcase
    if (conflict) err_now = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v_reg    <= '0;
      wr_v_reg    <= '0;
      dq_oe_reg   <= 1'b0;
      cmd_err_reg <= 1'b0;
    end else begin
      rd_v_reg    <= rd_v_next;
      wr_v_reg    <= wr_v_next;
      dq_oe_reg   <= rd_v_reg[CL-2];
      cmd_err_reg <= err_now;
    end
  end

  assign ddr4_dq_o  = dq_oe_reg ? rd_data_reg : 16'h0000;
  assign ddr4_dq_oe = dq_oe_reg;
  assign bank_open  = ready_vec;
  assign cmd_err    = cmd_err_reg;

`ifdef DDR4_RESP_STATS_EN
  logic [15:0] stat_act_reg, stat_rd_reg, stat_wr_reg, stat_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_act_reg <= '0;
      stat_rd_reg  <= '0;
      stat_wr_reg  <= '0;
      stat_err_reg <= '0;
    end else begin
      if (act_ok  && stat_act_reg != 16'hFFFF) stat_act_reg <= stat_act_reg + 1'b1;
      if (rd_ok   && stat_rd_reg  != 16'hFFFF) stat_rd_reg  <= stat_rd_reg + 1'b1;
      if (wr_ok   && stat_wr_reg  != 16'hFFFF) stat_wr_reg  <= stat_wr_reg + 1'b1;
      if (err_now && stat_err_reg != 16'hFFFF) stat_err_reg <= stat_err_reg + 1'b1;
    end
  end

  assign stat_act = stat_act_reg;
  assign stat_rd  = stat_rd_reg;
  assign stat_wr  = stat_wr_reg;
  assign stat_err = stat_err_reg;
`endif

endmodule
